// File: rtl/alu_rs_pkg.sv
// Shared types and widths for the ALU reservation station.
package alu_rs_pkg;

  localparam int unsigned OP_W        = 6;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned ROB_W       = 4;
  localparam int unsigned RS_SIZE_DEF = 8;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [OP_W-1:0]   openum_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ROB_W-1:0]  rob_index_t;

  typedef struct packed {
    logic       busy;
    openum_t    op;
    data_t      vj;
    rob_index_t qj;
    logic       has_qj;
    data_t      vk;
    rob_index_t qk;
    logic       has_qk;
    rob_index_t rob_index;
    addr_t      pc;
    data_t      imm;
  } rs_entry_t;

  typedef struct packed {
    logic       ready;
    openum_t    op;
    data_t      rs1;
    data_t      rs2;
    rob_index_t rob_index;
    addr_t      pc;
    data_t      imm;
  } rs_issue_t;

  // True when a valid CDB broadcast carries the tag an operand is waiting on.
  function automatic logic cdb_hit(input logic valid, input rob_index_t bus_tag,
                                   input rob_index_t want);
    return valid && (bus_tag == want);
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Fixed-priority finder: index of the lowest set bit plus a found flag.
module alu_rs_select
  import alu_rs_pkg::*;
#(
  parameter int unsigned N = RS_SIZE_DEF
) (
  input  logic [N-1:0]         vec_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 found_o
);

  localparam int unsigned IW = $clog2(N);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = FALSE;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IW'(i);
        found_o = TRUE;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: dispatch with CDB forwarding, wake-up, and
// lowest-index-first issue of one ready entry per cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int unsigned RS_SIZE = RS_SIZE_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic        dsp_valid,
  input  logic [5:0]  dsp_op,
  input  logic [31:0] dsp_pc,
  input  logic [31:0] dsp_imm,
  input  logic [3:0]  dsp_rob_index,
  input  logic [31:0] dsp_vj,
  input  logic [3:0]  dsp_qj,
  input  logic        dsp_has_qj,
  input  logic [31:0] dsp_vk,
  input  logic [3:0]  dsp_qk,
  input  logic        dsp_has_qk,
  input  logic        alu_ready,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_rob_index,
  input  logic        lsb_ready,
  input  logic [31:0] lsb_result,
  input  logic [3:0]  lsb_rob_index,
  output logic        rs_full,
  output logic        rs_to_alu_ready,
  output logic [5:0]  rs_to_alu_op,
  output logic [31:0] rs_to_alu_rs1,
  output logic [31:0] rs_to_alu_rs2,
  output logic [3:0]  rs_to_alu_rob_index,
  output logic [31:0] rs_to_alu_PC,
  output logic [31:0] rs_to_alu_imm
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);

  rs_entry_t           ent_q [RS_SIZE];
  rs_entry_t           ent_d [RS_SIZE];
  rs_issue_t           out_q;
  rs_issue_t           out_d;
  rs_entry_t           dsp_ent;
  logic [RS_SIZE-1:0]  free_vec;
  logic [RS_SIZE-1:0]  rdy_vec;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    rdy_idx;
  logic                free_found;
  logic                rdy_found;

  // Candidate vectors come from registered state only.
  always_comb begin
    free_vec = '0;
    rdy_vec  = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      free_vec[i] = ~ent_q[i].busy;
      rdy_vec[i]  = ent_q[i].busy & ~ent_q[i].has_qj & ~ent_q[i].has_qk;
    end
  end

  alu_rs_select #(.N(RS_SIZE)) u_free_sel (
    .vec_i   (free_vec),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  alu_rs_select #(.N(RS_SIZE)) u_rdy_sel (
    .vec_i   (rdy_vec),
    .idx_o   (rdy_idx),
    .found_o (rdy_found)
  );

  assign rs_full = ~free_found;

  // Incoming entry with same-cycle CDB forwarding; port 0 wins.
  always_comb begin
    dsp_ent           = '0;
    dsp_ent.busy      = TRUE;
    dsp_ent.op        = dsp_op;
    dsp_ent.vj        = dsp_vj;
    dsp_ent.qj        = dsp_qj;
    dsp_ent.has_qj    = dsp_has_qj;
    dsp_ent.vk        = dsp_vk;
    dsp_ent.qk        = dsp_qk;
    dsp_ent.has_qk    = dsp_has_qk;
    dsp_ent.rob_index = dsp_rob_index;
    dsp_ent.pc        = dsp_pc;
    dsp_ent.imm       = dsp_imm;
    if (dsp_has_qj) begin
      if (cdb_hit(alu_ready, alu_rob_index, dsp_qj)) begin
        dsp_ent.vj     = alu_result;
        dsp_ent.has_qj = FALSE;
      end else if (cdb_hit(lsb_ready, lsb_rob_index, dsp_qj)) begin
        dsp_ent.vj     = lsb_result;
        dsp_ent.has_qj = FALSE;
      end
    end
    if (dsp_has_qk) begin
      if (cdb_hit(alu_ready, alu_rob_index, dsp_qk)) begin
        dsp_ent.vk     = alu_result;
        dsp_ent.has_qk = FALSE;
      end else if (cdb_hit(lsb_ready, lsb_rob_index, dsp_qk)) begin
        dsp_ent.vk     = lsb_result;
        dsp_ent.has_qk = FALSE;
      end
    end
  end

  always_comb begin
    ent_d = ent_q;
    out_d = out_q;
    if (rdy_in) begin
      if (clr_in) begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          ent_d[i].busy = FALSE;
        end
        out_d = '0;
      end else begin
        out_d = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          if (ent_q[i].busy && ent_q[i].has_qj) begin
            if (cdb_hit(alu_ready, alu_rob_index, ent_q[i].qj)) begin
              ent_d[i].vj     = alu_result;
              ent_d[i].has_qj = FALSE;
            end else if (cdb_hit(lsb_ready, lsb_rob_index, ent_q[i].qj)) begin
              ent_d[i].vj     = lsb_result;
              ent_d[i].has_qj = FALSE;
            end
          end
          if (ent_q[i].busy && ent_q[i].has_qk) begin
            if (cdb_hit(alu_ready, alu_rob_index, ent_q[i].qk)) begin
              ent_d[i].vk     = alu_result;
              ent_d[i].has_qk = FALSE;
            end else if (cdb_hit(lsb_ready, lsb_rob_index, ent_q[i].qk)) begin
              ent_d[i].vk     = lsb_result;
              ent_d[i].has_qk = FALSE;
            end
          end
        end
        if (rdy_found) begin
          ent_d[rdy_idx].busy = FALSE;
          out_d.ready         = TRUE;
          out_d.op            = ent_q[rdy_idx].op;
          out_d.rs1           = ent_q[rdy_idx].vj;
          out_d.rs2           = ent_q[rdy_idx].vk;
          out_d.rob_index     = ent_q[rdy_idx].rob_index;
          out_d.pc            = ent_q[rdy_idx].pc;
          out_d.imm           = ent_q[rdy_idx].imm;
        end
        // Issued slot is busy and the free slot is not, so they never collide.
        if (dsp_valid && free_found) begin
          ent_d[free_idx] = dsp_ent;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        ent_q[i] <= '0;
      end
      out_q <= '0;
    end else begin
      ent_q <= ent_d;
      out_q <= out_d;
    end
  end

  assign rs_to_alu_ready     = out_q.ready;
  assign rs_to_alu_op        = out_q.op;
  assign rs_to_alu_rs1       = out_q.rs1;
  assign rs_to_alu_rs2       = out_q.rs2;
  assign rs_to_alu_rob_index = out_q.rob_index;
  assign rs_to_alu_PC        = out_q.pc;
  assign rs_to_alu_imm       = out_q.imm;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a behavioural model.
module tb_alu_rs;

  localparam int RS = 8;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in;
  logic        dsp_valid, dsp_has_qj, dsp_has_qk;
  logic [5:0]  dsp_op;
  logic [31:0] dsp_pc, dsp_imm, dsp_vj, dsp_vk;
  logic [3:0]  dsp_rob_index, dsp_qj, dsp_qk;
  logic        alu_ready, lsb_ready;
  logic [31:0] alu_result, lsb_result;
  logic [3:0]  alu_rob_index, lsb_rob_index;
  logic        rs_full, rs_to_alu_ready;
  logic [5:0]  rs_to_alu_op;
  logic [31:0] rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_PC, rs_to_alu_imm;
  logic [3:0]  rs_to_alu_rob_index;

  always #5 clk_in = ~clk_in;

  alu_rs #(.RS_SIZE(RS)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .dsp_valid(dsp_valid), .dsp_op(dsp_op), .dsp_pc(dsp_pc), .dsp_imm(dsp_imm),
    .dsp_rob_index(dsp_rob_index), .dsp_vj(dsp_vj), .dsp_qj(dsp_qj),
    .dsp_has_qj(dsp_has_qj), .dsp_vk(dsp_vk), .dsp_qk(dsp_qk), .dsp_has_qk(dsp_has_qk),
    .alu_ready(alu_ready), .alu_result(alu_result), .alu_rob_index(alu_rob_index),
    .lsb_ready(lsb_ready), .lsb_result(lsb_result), .lsb_rob_index(lsb_rob_index),
    .rs_full(rs_full), .rs_to_alu_ready(rs_to_alu_ready), .rs_to_alu_op(rs_to_alu_op),
    .rs_to_alu_rs1(rs_to_alu_rs1), .rs_to_alu_rs2(rs_to_alu_rs2),
    .rs_to_alu_rob_index(rs_to_alu_rob_index), .rs_to_alu_PC(rs_to_alu_PC),
    .rs_to_alu_imm(rs_to_alu_imm)
  );

  typedef struct {
    bit        busy;
    bit [5:0]  op;
    bit [31:0] vj, vk, pc, imm;
    bit [3:0]  qj, qk, rob;
    bit        hj, hk;
  } ment_t;

  ment_t     m [RS];
  bit        e_ready;
  bit [5:0]  e_op;
  bit [31:0] e_rs1, e_rs2, e_pc, e_imm;
  bit [3:0]  e_rob;
  int        checks = 0;
  int        passed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic bit m_full();
    foreach (m[i]) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // Value broadcast for a tag this cycle, ALU port taking precedence.
  function automatic bit cdb_lookup(input bit [3:0] tag, output bit [31:0] val);
    val = '0;
    if (alu_ready && alu_rob_index == tag) begin val = alu_result; return 1'b1; end
    if (lsb_ready && lsb_rob_index == tag) begin val = lsb_result; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic model_reset();
    foreach (m[i]) m[i] = '{default: '0};
    e_ready = 0; e_op = 0; e_rs1 = 0; e_rs2 = 0; e_pc = 0; e_imm = 0; e_rob = 0;
  endtask

  // One clock edge of the station, computed from the inputs currently driven.
  task automatic model_step();
    ment_t     n [RS];
    bit [31:0] v;
    int        slot;
    if (!rdy_in) return;
    if (clr_in) begin
      foreach (m[i]) m[i].busy = 0;
      e_ready = 0; e_op = 0; e_rs1 = 0; e_rs2 = 0; e_pc = 0; e_imm = 0; e_rob = 0;
      return;
    end
    n = m;
    e_ready = 0; e_op = 0; e_rs1 = 0; e_rs2 = 0; e_pc = 0; e_imm = 0; e_rob = 0;
    for (int i = 0; i < RS; i++) begin
      if (m[i].busy && !m[i].hj && !m[i].hk) begin
        e_ready = 1; e_op = m[i].op; e_rs1 = m[i].vj; e_rs2 = m[i].vk;
        e_rob = m[i].rob; e_pc = m[i].pc; e_imm = m[i].imm;
        n[i].busy = 0;
        break;
      end
    end
    for (int i = 0; i < RS; i++) begin
      if (m[i].busy && m[i].hj && cdb_lookup(m[i].qj, v)) begin n[i].vj = v; n[i].hj = 0; end
      if (m[i].busy && m[i].hk && cdb_lookup(m[i].qk, v)) begin n[i].vk = v; n[i].hk = 0; end
    end
    if (dsp_valid && !m_full()) begin
      slot = 0;
      while (m[slot].busy) slot++;
      n[slot] = '{busy: 1, op: dsp_op, vj: dsp_vj, vk: dsp_vk, pc: dsp_pc, imm: dsp_imm,
                  qj: dsp_qj, qk: dsp_qk, rob: dsp_rob_index, hj: dsp_has_qj, hk: dsp_has_qk};
      if (dsp_has_qj && cdb_lookup(dsp_qj, v)) begin n[slot].vj = v; n[slot].hj = 0; end
      if (dsp_has_qk && cdb_lookup(dsp_qk, v)) begin n[slot].vk = v; n[slot].hk = 0; end
    end
    m = n;
  endtask

  task automatic check_all();
    chk("rs_full", rs_full, m_full());
    chk("ready", rs_to_alu_ready, e_ready);
    chk("op", rs_to_alu_op, e_op);
    chk("rs1", rs_to_alu_rs1, e_rs1);
    chk("rs2", rs_to_alu_rs2, e_rs2);
    chk("rob", rs_to_alu_rob_index, e_rob);
    chk("pc", rs_to_alu_PC, e_pc);
    chk("imm", rs_to_alu_imm, e_imm);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_in);
    #1;
    check_all();
  endtask

  task automatic idle();
    rdy_in = 1; clr_in = 0; dsp_valid = 0; alu_ready = 0; lsb_ready = 0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] vj, input logic hj,
                      input logic [3:0] qj, input logic [31:0] vk, input logic hk,
                      input logic [3:0] qk, input logic [3:0] rob);
    dsp_valid = 1; dsp_op = op; dsp_vj = vj; dsp_has_qj = hj; dsp_qj = qj;
    dsp_vk = vk; dsp_has_qk = hk; dsp_qk = qk; dsp_rob_index = rob;
    dsp_pc = 32'h1000 + 32'(rob) * 4; dsp_imm = 32'h100 + 32'(rob);
  endtask

  task automatic cdb(input bit port, input logic [3:0] tag, input logic [31:0] val);
    if (!port) begin alu_ready = 1; alu_rob_index = tag; alu_result = val; end
    else begin lsb_ready = 1; lsb_rob_index = tag; lsb_result = val; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    dsp_op = 0; dsp_pc = 0; dsp_imm = 0; dsp_rob_index = 0; dsp_vj = 0; dsp_qj = 0;
    dsp_has_qj = 0; dsp_vk = 0; dsp_qk = 0; dsp_has_qk = 0;
    alu_result = 0; alu_rob_index = 0; lsb_result = 0; lsb_rob_index = 0;
    rst_in = 1;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1 rst_in = 0;
    check_all();
    chk("reset_ready", rs_to_alu_ready, 0);

    // Operand-complete ADD issues one edge after dispatch.
    disp(6'h01, 5, 0, 0, 7, 0, 0, 4'd5); cycle(); idle();
    chk("add_not_yet", rs_to_alu_ready, 0);
    cycle();
    chk("add_ready", rs_to_alu_ready, 1); chk("add_rs1", rs_to_alu_rs1, 5);
    chk("add_rs2", rs_to_alu_rs2, 7);     chk("add_rob", rs_to_alu_rob_index, 5);
    cycle(); chk("add_one_shot", rs_to_alu_ready, 0);

    // Pending qj woken by the ALU port two cycles after dispatch.
    disp(6'h02, 0, 1, 4'd3, 0, 0, 0, 4'd6); cycle(); idle(); cycle();
    cdb(0, 4'd3, 32'h10); cycle(); idle();
    chk("wake_not_yet", rs_to_alu_ready, 0);
    cycle();
    chk("wake_ready", rs_to_alu_ready, 1); chk("wake_rs1", rs_to_alu_rs1, 32'h10);
    chk("wake_rob", rs_to_alu_rob_index, 6);

    // Forwarding from the LSB port during dispatch.
    disp(6'h03, 0, 1, 4'd2, 9, 0, 0, 4'd7); cdb(1, 4'd2, 32'hABCD); cycle(); idle(); cycle();
    chk("fwd_ready", rs_to_alu_ready, 1); chk("fwd_rs1", rs_to_alu_rs1, 32'hABCD);
    chk("fwd_rob", rs_to_alu_rob_index, 7);
    cycle();

    // Fill, reject when full, free slot 3, refill slot 3.
    for (int i = 0; i < RS; i++) begin
      disp(6'h04, 0, 1, 4'(8 + i), 0, 0, 0, 4'(i)); cycle();
    end
    idle(); chk("full_set", rs_full, 1);
    disp(6'h05, 1, 0, 0, 2, 0, 0, 4'd15); cycle(); idle();
    chk("full_ignored", rs_to_alu_ready, 0); chk("full_still", rs_full, 1);
    cdb(0, 4'd11, 32'h33); cycle(); idle(); cycle();
    chk("slot3_issue", rs_to_alu_ready, 1); chk("slot3_rob", rs_to_alu_rob_index, 3);
    chk("slot3_rs1", rs_to_alu_rs1, 32'h33); chk("full_clear", rs_full, 0);
    disp(6'h06, 0, 1, 4'd13, 0, 0, 0, 4'd9); cycle(); idle();
    chk("refull", rs_full, 1);
    cdb(1, 4'd13, 32'h77); cycle(); idle(); cycle();
    chk("refill_rob", rs_to_alu_rob_index, 9); chk("refill_rs1", rs_to_alu_rs1, 32'h77);
    cycle(); chk("entry5_rob", rs_to_alu_rob_index, 5);

    // Flush with a ready dispatch in the same cycle.
    clr_in = 1; disp(6'h07, 1, 0, 0, 1, 0, 0, 4'd1); cycle(); idle();
    chk("clr_ready", rs_to_alu_ready, 0); chk("clr_full", rs_full, 0);
    cycle(); chk("clr_dsp_dropped", rs_to_alu_ready, 0);

    // Two entries woken together issue lowest index first.
    for (int i = 0; i < 5; i++) begin
      disp(6'h08, 0, 1, 4'(8 + i), 0, 0, 0, 4'(i)); cycle();
    end
    idle(); cdb(0, 4'd9, 32'h91); cdb(1, 4'd12, 32'h94); cycle(); idle(); cycle();
    chk("prio_first", rs_to_alu_rob_index, 1); chk("prio_first_rs1", rs_to_alu_rs1, 32'h91);
    cycle();
    chk("prio_second", rs_to_alu_rob_index, 4); chk("prio_second_rs1", rs_to_alu_rs1, 32'h94);
    cdb(0, 4'd8, 32'hA); cdb(1, 4'd8, 32'hB); cycle(); idle(); cycle();
    chk("port0_prio_rs1", rs_to_alu_rs1, 32'hA); chk("port0_prio_rob", rs_to_alu_rob_index, 0);

    // Asynchronous reset in the middle of a cycle.
    disp(6'h09, 3, 0, 0, 4, 0, 0, 4'd12); cycle(); idle(); cycle();
    chk("pre_rst_ready", rs_to_alu_ready, 1);
    #3 rst_in = 1;
    #1 chk("rst_async_ready", rs_to_alu_ready, 0); chk("rst_async_rob", rs_to_alu_rob_index, 0);
    chk("rst_async_full", rs_full, 0);
    model_reset();
    @(posedge clk_in); #1 rst_in = 0;
    cycle(); chk("post_rst_no_issue", rs_to_alu_ready, 0);

    // Stall: rdy_in low freezes outputs, ignores dispatch and CDB.
    disp(6'h0A, 1, 0, 0, 1, 0, 0, 4'd1); cycle();
    disp(6'h0A, 2, 0, 0, 2, 0, 0, 4'd2); cycle();
    idle(); rdy_in = 0; disp(6'h0B, 3, 0, 0, 3, 0, 0, 4'd3); cdb(0, 4'd0, 32'h5);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_ready", rs_to_alu_ready, 1); chk("stall_rob", rs_to_alu_rob_index, 1);
    end
    idle(); cycle(); chk("resume_rob", rs_to_alu_rob_index, 2);
    cycle(); chk("resume_empty", rs_to_alu_ready, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rdy_in        = ($urandom % 10) != 0;
      clr_in        = ($urandom % 50) == 0;
      dsp_valid     = ($urandom % 10) < 6;
      dsp_op        = 6'($urandom);
      dsp_pc        = $urandom;
      dsp_imm       = $urandom;
      dsp_rob_index = 4'($urandom);
      dsp_vj        = $urandom;
      dsp_vk        = $urandom;
      dsp_qj        = 4'($urandom_range(0, 7));
      dsp_qk        = 4'($urandom_range(0, 7));
      dsp_has_qj    = 1'($urandom);
      dsp_has_qk    = 1'($urandom);
      alu_ready     = ($urandom % 10) < 4;
      alu_rob_index = 4'($urandom_range(0, 7));
      alu_result    = $urandom;
      lsb_ready     = ($urandom % 10) < 3;
      lsb_rob_index = 4'($urandom_range(0, 7));
      lsb_result    = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter RS_SIZE, default 8, number of reservation-station entries (power of two, 2..16).
REQ-002 clk_in  input  1  single clock; all state on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 rdy_in  input  1  global enable; low freezes all state and outputs.
REQ-005 clr_in  input  1  synchronous flush (mispredict), qualified by rdy_in.
REQ-006 dsp_valid, dsp_op[6], dsp_pc[32], dsp_imm[32], dsp_rob_index[4]  input  dispatch instruction.
REQ-007 dsp_vj[32], dsp_qj[4], dsp_has_qj[1], dsp_vk[32], dsp_qk[4], dsp_has_qk[1]  input  operand value or pending ROB tag.
REQ-008 alu_ready[1], alu_result[32], alu_rob_index[4]  input  ALU broadcast (CDB port 0).
REQ-009 lsb_ready[1], lsb_result[32], lsb_rob_index[4]  input  load/store broadcast (CDB port 1).
REQ-010 rs_full  output  1  combinational; all entries busy.
REQ-011 rs_to_alu_ready, rs_to_alu_op[6], rs_to_alu_rs1[32], rs_to_alu_rs2[32], rs_to_alu_rob_index[4], rs_to_alu_PC[32], rs_to_alu_imm[32]  output  registered issue to ALU.

Function
REQ-012 Each entry holds busy, op, vj, qj, has_qj, vk, qk, has_qk, rob_index, pc, imm.
REQ-013 Dispatch (dsp_valid=1, rs_full=0) writes lowest-index non-busy entry at next edge, busy=1.
REQ-014 Dispatch while rs_full=1 is ignored; no entry changes.
REQ-015 Dispatch forwarding: if has_qj=1 and a CDB port in the same cycle carries tag qj, entry stores that result with has_qj=0; same for k.
REQ-016 Wake-up: each edge, every busy entry with has_qj=1 and qj matching a valid CDB tag captures the value and clears has_qj; same for k; both ports checked in parallel, port 0 priority if both match.
REQ-017 Entry ready = busy & !has_qj & !has_qk, evaluated on registered state (wake-up at edge E makes entry eligible for selection in cycle after E).
REQ-018 Selection: fixed priority, lowest-index ready entry; at most one issue per cycle.
REQ-019 On issue edge: selected entry busy=0; outputs registered with its fields, rs_to_alu_ready=1 for exactly one cycle.
REQ-020 No ready entry: rs_to_alu_ready=0 next cycle, other outputs don't-care (driven 0).
REQ-021 Latency: operand-complete dispatch at edge E0 -> issued at edge E1 -> ALU result on CDB in cycle after E1.
REQ-022 Slot freed by issue at edge E is usable by a dispatch only from cycle after E (rs_full uses registered busy).
REQ-023 clr_in=1 & rdy_in=1: all busy cleared, rs_to_alu_ready=0 at next edge; dispatch and issue that cycle discarded.
REQ-024 rdy_in=0: entries, outputs, CDB captures all frozen; CDB broadcasts in such cycles are not captured.
REQ-025 Tag width and 32-bit values are stored without modification; no arithmetic in this block.

Reset
REQ-026 rst_in=1 asynchronously clears all busy bits and drives every output register to 0; rs_full=0 after reset.
REQ-027 Reset mid-operation discards all entries and any pending issue; no issue in first cycle after release.

Structure
REQ-028 def.v holds OPENUM_TYPE, DATA_TYPE, ADDR_TYPE, ROB_INDEX_TYPE, RS_SIZE, RS_INDEX_TYPE, TRUE/FALSE.
REQ-029 One sub-module alu_rs_select: RS_SIZE-bit vector -> lowest-set index plus found flag; instanced twice (free slot, ready entry).

Verification
REQ-030 Dispatch ADD vj=5, vk=7 no tags into empty RS -> rs_to_alu_ready=1 one cycle later with rs1=5, rs2=7, rob_index as dispatched.
REQ-031 Dispatch ADDI qj=3 pending; two cycles later alu_ready=1 tag 3 result 0x10 -> issue next-but-one cycle with rs1=0x10.
REQ-032 Dispatch with qj=2 while lsb broadcasts tag 2 value 0xABCD same cycle -> stored forwarded, issue one cycle after dispatch.
REQ-033 Fill 8 blocked entries -> rs_full=1; 9th dispatch ignored; wake entry 3 -> it issues, rs_full=0 next cycle, then new dispatch lands in slot 3.
REQ-034 Entries 1 and 4 ready together -> entry 1 issues first, entry 4 next cycle.
REQ-035 clr_in with 5 busy entries -> all freed, no issue next cycle; rst_in pulse mid-cycle -> outputs 0 immediately; rdy_in=0 for 3 cycles -> state and outputs unchanged.
